// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the buffered UART transmitter.
//   uart_tx_state_t : transmitter FSM states (PARITY only reached when
//                     UART_TX_PARITY_EN is defined)
//   calcDiv         : clock cycles per bit, CLK_FREQ/BAUD truncated
//   cntWidth        : bits needed for a counter running 0..n-1
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  function automatic int calcDiv(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

  // A counter that must reach n-1 needs at least one bit even for tiny n.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with first-word-fall-through read data and registered
// status flags.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-low reset
//   i_push       : write request, ignored (and flagged) while full
//   i_pushData   : word to write
//   i_pop        : read request, ignored while empty
//   o_popData    : word at the head of the FIFO, valid while not empty
//   o_level      : registered entry count, one bit wider than the pointers
//   o_full       : registered, level == DEPTH
//   o_empty      : registered, level == 0
//   o_overflow   : sticky, set by any push attempted while full
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_pushData,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_popData,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_level;
  logic             r_full;
  logic             r_empty;
  logic             r_overflow;

  logic             w_doPush;
  logic             w_doPop;
  logic [AW:0]      w_levelNext;

  // Full and empty come from the registered level, so a push into a full
  // FIFO is dropped even when a pop frees a slot on the same edge.
  assign w_doPush = i_push && !r_full;
  assign w_doPop  = i_pop && !r_empty;

  // Level only moves when exactly one of push/pop takes effect.
  always_comb begin
    w_levelNext = r_level;
    case ({w_doPush, w_doPop})
      2'b10:   w_levelNext = r_level + 1'b1;
      2'b01:   w_levelNext = r_level - 1'b1;
      default: w_levelNext = r_level;
    endcase
  end

  // Pointers wrap naturally at the power-of-two depth; flags are
  // precomputed from the next level so they are registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_level <= w_levelNext;
      r_full  <= (w_levelNext == FULL_LEVEL);
      r_empty <= (w_levelNext == '0);
      if (i_push && r_full) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
  end

  assign o_popData  = r_mem[r_rdPtr];
  assign o_level    = r_level;
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf
// Buffered UART transmitter: bytes pushed by the CPU side queue in a FIFO
// and are serialised LSB first onto tx, back-to-back while data remains.
// Optional macro: UART_TX_PARITY_EN adds the parity_odd input and a parity
// bit (^data ^ parity_odd) between the data and stop bits.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-low reset
//   wr_en       : push request
//   wr_data     : word to push (DATA_BITS wide)
//   parity_odd  : (parity build only) 0 = even, 1 = odd, sampled on pop
//   full, empty : FIFO status
//   level       : FIFO entry count
//   overflow    : sticky, a push was attempted while full
//   busy        : a frame is being shifted out
//   tx          : serial line, idle high
module uart_tx_buf #(
  parameter int CLK_FREQ   = 20_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);

  import uart_pkg::*;

  localparam int DIV = calcDiv(CLK_FREQ, BAUD);
  localparam int BW  = cntWidth(DIV);
  localparam int CW  = cntWidth(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  uart_tx_state_t         r_state;
  uart_tx_state_t         w_stateNext;
  logic [BW-1:0]          r_baudCnt;
  logic [BW-1:0]          w_baudNext;
  logic [CW-1:0]          r_bitCnt;
  logic [CW-1:0]          w_bitNext;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shiftNext;
  logic                   r_tx;
  logic                   w_txNext;
  logic                   r_busy;
  logic                   w_baudDone;
  logic                   w_pop;
  logic [DATA_BITS-1:0]   w_fifoData;
  logic                   w_fifoEmpty;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity;
  logic                   w_parityNext;
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (wr_en),
    .i_pushData (wr_data),
    .i_pop      (w_pop),
    .o_popData  (w_fifoData),
    .o_level    (level),
    .o_full     (full),
    .o_empty    (w_fifoEmpty),
    .o_overflow (overflow)
  );

  assign w_baudDone = (r_baudCnt == BAUD_LAST);

  // Next-state logic. The baud counter is cleared on every state change;
  // the bit counter is shared between DATA and STOP. The shift register is
  // loaded on pop and shifted right after each data bit, so bit 0 is
  // always the bit on the line during DATA.
  always_comb begin
    w_stateNext  = r_state;
    w_baudNext   = r_baudCnt + 1'b1;
    w_bitNext    = r_bitCnt;
    w_shiftNext  = r_shift;
    w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parityNext = r_parity;
`endif
    case (r_state)
      IDLE: begin
        w_baudNext = '0;
        if (!w_fifoEmpty) begin
          w_pop        = 1'b1;
          w_shiftNext  = w_fifoData;
`ifdef UART_TX_PARITY_EN
          w_parityNext = (^w_fifoData) ^ parity_odd;
`endif
          w_stateNext  = START;
        end
      end
      START: begin
        if (w_baudDone) begin
          w_baudNext  = '0;
          w_bitNext   = '0;
          w_stateNext = DATA;
        end
      end
      DATA: begin
        if (w_baudDone) begin
          w_baudNext  = '0;
          w_shiftNext = r_shift >> 1;
          if (r_bitCnt == DATA_LAST) begin
            w_bitNext   = '0;
`ifdef UART_TX_PARITY_EN
            w_stateNext = PARITY;
`else
            w_stateNext = STOP;
`endif
          end else begin
            w_bitNext = r_bitCnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_baudDone) begin
          w_baudNext  = '0;
          w_bitNext   = '0;
          w_stateNext = STOP;
        end
      end
`endif
      STOP: begin
        if (w_baudDone) begin
          w_baudNext = '0;
          if (r_bitCnt == STOP_LAST) begin
            w_bitNext = '0;
            // Chain straight into the next start bit when data is waiting.
            if (!w_fifoEmpty) begin
              w_pop        = 1'b1;
              w_shiftNext  = w_fifoData;
`ifdef UART_TX_PARITY_EN
              w_parityNext = (^w_fifoData) ^ parity_odd;
`endif
              w_stateNext  = START;
            end else begin
              w_stateNext = IDLE;
            end
          end else begin
            w_bitNext = r_bitCnt + 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // The line level is derived from the state being entered so tx can be
  // registered without lagging the state by a cycle.
  always_comb begin
    w_txNext = 1'b1;
    case (w_stateNext)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_shiftNext[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_txNext = w_parityNext;
`endif
      default: w_txNext = 1'b1;
    endcase
  end

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_stateNext;
      r_baudCnt <= w_baudNext;
      r_bitCnt  <= w_bitNext;
      r_shift   <= w_shiftNext;
      r_tx      <= w_txNext;
      r_busy    <= (w_stateNext != IDLE);
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parityNext;
`endif
    end
  end

  assign empty = w_fifoEmpty;
  assign busy  = r_busy;
  assign tx    = r_tx;

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf
// Self-checking bench for uart_tx_buf with DIV = 4 and a 4-entry FIFO.
// A reference model holds the FIFO as a queue and the line as a queue of
// per-cycle levels built from each popped byte; a serial receiver decodes
// frames from tx and matches them against the bytes the model sent.
// Defining UART_TX_PARITY_EN selects the parity build with two stop bits.
module tb_uart_tx_buf;

  localparam int CLK_FREQ   = 40;
  localparam int BAUD       = 10;
  localparam int DIV        = 4;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int STOP_BITS  = 2;
  localparam int PBITS      = 1;
`else
  localparam int STOP_BITS  = 1;
  localparam int PBITS      = 0;
`endif
  localparam int FRAME = (1 + DATA_BITS + PBITS + STOP_BITS) * DIV;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  logic          clk     = 1'b0;
  logic          reset   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [7:0]    wr_data = '0;
`ifdef UART_TX_PARITY_EN
  logic          parityOdd = 1'b0;
`endif
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic          busy;
  logic          tx;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  uart_tx_buf #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .DATA_BITS  (DATA_BITS),
    .STOP_BITS  (STOP_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
`ifdef UART_TX_PARITY_EN
    .parity_odd (parityOdd),
`endif
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .busy       (busy),
    .tx         (tx)
  );

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of write inputs and advance to the next falling edge.
  task automatic applyStimulus(input logic en, input logic [7:0] data);
    wr_en   = en;
    wr_data = data;
    @(negedge clk);
  endtask

  // Reference model state.
  logic [7:0] mQ[$];
  logic       mWave[$];
  logic [7:0] mSent[$];
`ifdef UART_TX_PARITY_EN
  logic       mParQ[$];
`endif
  logic       mTx       = 1'b1;
  logic       mBusy     = 1'b0;
  logic       mOverflow = 1'b0;

  // Receiver state.
  logic       rxActive = 1'b0;
  int         rxT      = 0;
  logic [7:0] rxByte   = '0;
  logic       rxPar    = 1'b0;
  int         rxCount  = 0;

  // Expands one byte into the line level for every cycle of its frame.
  task automatic buildFrame(input logic [7:0] b, input logic parBit);
    for (int k = 0; k < DIV; k++) mWave.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++)
      for (int k = 0; k < DIV; k++) mWave.push_back(b[i]);
    if (PBITS != 0)
      for (int k = 0; k < DIV; k++) mWave.push_back(parBit);
    for (int k = 0; k < STOP_BITS * DIV; k++) mWave.push_back(1'b1);
  endtask

  // Model step at each rising edge, then compare and decode 1 time unit
  // later once the registered outputs have settled.
  always @(posedge clk) begin
    int         preLevel;
    logic [7:0] b;
    logic       pb;
    if (!reset) begin
      mQ.delete();
      mWave.delete();
      mSent.delete();
`ifdef UART_TX_PARITY_EN
      mParQ.delete();
`endif
      mTx       = 1'b1;
      mBusy     = 1'b0;
      mOverflow = 1'b0;
    end else begin
      preLevel = mQ.size();
      if (mWave.size() == 0 && preLevel > 0) begin
        b  = mQ.pop_front();
        pb = 1'b0;
`ifdef UART_TX_PARITY_EN
        pb = (^b) ^ parityOdd;
        mParQ.push_back(pb);
`endif
        mSent.push_back(b);
        buildFrame(b, pb);
      end
      if (wr_en) begin
        if (preLevel == FIFO_DEPTH) mOverflow = 1'b1;
        else                        mQ.push_back(wr_data);
      end
      if (mWave.size() > 0) begin
        mTx   = mWave.pop_front();
        mBusy = 1'b1;
      end else begin
        mTx   = 1'b1;
        mBusy = 1'b0;
      end
    end

    #1;
    checkOutput("tx",       32'(tx),       32'(mTx));
    checkOutput("busy",     32'(busy),     32'(mBusy));
    checkOutput("overflow", 32'(overflow), 32'(mOverflow));
    checkOutput("level",    32'(level),    32'(mQ.size()));
    checkOutput("full",     32'(full),     32'(mQ.size() == FIFO_DEPTH));
    checkOutput("empty",    32'(empty),    32'(mQ.size() == 0));

    if (!reset) begin
      rxActive = 1'b0;
    end else if (!rxActive) begin
      if (tx == 1'b0) begin
        rxActive = 1'b1;
        rxT      = 1;
        rxByte   = '0;
      end
    end else begin
      for (int i = 0; i < DATA_BITS; i++)
        if (rxT == DIV * (1 + i) + DIV / 2) rxByte[i] = tx;
      if (rxT == DIV * (1 + DATA_BITS) + DIV / 2) rxPar = tx;
      for (int s = 0; s < STOP_BITS; s++)
        if (rxT == DIV * (1 + DATA_BITS + PBITS + s) + DIV / 2)
          checkOutput("rx_stop", 32'(tx), 32'd1);
      if (rxT == FRAME - 1) begin
        rxActive = 1'b0;
        rxCount++;
        checkOutput("rx_pending", 32'(mSent.size() > 0), 32'd1);
        if (mSent.size() > 0) begin
          b = mSent.pop_front();
          checkOutput("rx_byte", 32'(rxByte), 32'(b));
`ifdef UART_TX_PARITY_EN
          pb = mParQ.pop_front();
          checkOutput("rx_parity", 32'(rxPar), 32'(pb));
`endif
        end
      end else begin
        rxT++;
      end
    end
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] b2b [3];
    int         peak;
    int         busyCnt;
    int         falls;
    int         rxBase;
    int         pct;
    logic       prevBusy;

    // Reset held for three cycles.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx",       32'(tx),       32'd1);
    checkOutput("rst_busy",     32'(busy),     32'd0);
    checkOutput("rst_empty",    32'(empty),    32'd1);
    checkOutput("rst_level",    32'(level),    32'd0);
    checkOutput("rst_full",     32'(full),     32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: start bit two edges after the write, LSB first.
    $display("[TB] single byte");
    pat = 8'hA5;
    applyStimulus(1'b1, pat);
    wr_en = 1'b0;
    checkOutput("sb_level", 32'(level), 32'd1);
    @(negedge clk);
    checkOutput("sb_start", 32'(tx), 32'd0);
    checkOutput("sb_busy",  32'(busy), 32'd1);
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      checkOutput($sformatf("sb_bit%0d", i), 32'(tx), 32'(pat[i]));
      repeat (DIV) @(negedge clk);
    end
    repeat (PBITS * DIV) @(negedge clk);
    checkOutput("sb_stop", 32'(tx), 32'd1);
    repeat (FRAME - DIV * (1 + DATA_BITS + PBITS) - 1) @(negedge clk);
    checkOutput("sb_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("sb_busy_drop", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    // Three consecutive pushes produce three contiguous frames.
    $display("[TB] back-to-back");
    b2b      = '{8'h00, 8'hFF, 8'h55};
    peak     = 0;
    busyCnt  = 0;
    falls    = 0;
    prevBusy = 1'b0;
    rxBase   = rxCount;
    for (int c = 0; c < 3 * FRAME + 20; c++) begin
      if (c < 3) applyStimulus(1'b1, b2b[c]);
      else       applyStimulus(1'b0, 8'h00);
      if (int'(level) > peak) peak = int'(level);
      if (busy) busyCnt++;
      if (prevBusy && !busy) falls++;
      prevBusy = busy;
    end
    checkOutput("b2b_peak",   32'(peak),             32'd2);
    checkOutput("b2b_busy",   32'(busyCnt),          32'(3 * FRAME));
    checkOutput("b2b_gaps",   32'(falls),            32'd1);
    checkOutput("b2b_frames", 32'(rxCount - rxBase), 32'd3);
    checkOutput("b2b_empty",  32'(empty),            32'd1);

    // Six pushes while a frame is in flight: four fit, two are dropped.
    $display("[TB] overflow");
    rxBase = rxCount;
    applyStimulus(1'b1, 8'h3C);
    wr_en = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'($urandom));
    wr_en = 1'b0;
    checkOutput("ovf_full",     32'(full),     32'd1);
    checkOutput("ovf_flag",     32'(overflow), 32'd1);
    checkOutput("ovf_level",    32'(level),    32'd4);
    repeat (5 * FRAME + 20) @(negedge clk);
    checkOutput("ovf_frames",   32'(rxCount - rxBase), 32'd5);
    checkOutput("ovf_empty",    32'(empty),    32'd1);
    checkOutput("ovf_sticky",   32'(overflow), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("ovf_cleared",  32'(overflow), 32'd0);
    repeat (3) @(negedge clk);

    // Reset during the third data bit aborts the frame.
    $display("[TB] mid-frame reset");
    applyStimulus(1'b1, 8'hC3);
    wr_en = 1'b0;
    @(negedge clk);
    repeat (DIV + 2 * DIV + 2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mr_tx",    32'(tx),    32'd1);
    checkOutput("mr_level", 32'(level), 32'd0);
    checkOutput("mr_busy",  32'(busy),  32'd0);
    checkOutput("mr_empty", 32'(empty), 32'd1);
    reset  = 1'b1;
    rxBase = rxCount;
    repeat (2 * FRAME) @(negedge clk);
    checkOutput("mr_noframe", 32'(rxCount - rxBase), 32'd0);
    checkOutput("mr_idle",    32'(busy),             32'd0);

`ifdef UART_TX_PARITY_EN
    // Even parity of 0x07 is 1; two stop bits give a 48-cycle frame.
    $display("[TB] parity");
    parityOdd = 1'b0;
    applyStimulus(1'b1, 8'h07);
    wr_en = 1'b0;
    @(negedge clk);
    repeat (DIV * (1 + DATA_BITS)) @(negedge clk);
    checkOutput("par_bit",   32'(tx), 32'd1);
    repeat (DIV) @(negedge clk);
    checkOutput("par_stop1", 32'(tx), 32'd1);
    repeat (DIV) @(negedge clk);
    checkOutput("par_stop2", 32'(tx), 32'd1);
    repeat (DIV - 1) @(negedge clk);
    checkOutput("par_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("par_busy_drop", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
`endif

    // Randomised traffic at varying push rates with occasional resets.
    $display("[TB] random traffic");
    for (int chunk = 0; chunk < 8; chunk++) begin
      pct = int'($urandom_range(0, 12));
      for (int c = 0; c < 200; c++) begin
        wr_en   = ($urandom_range(0, 99) < pct);
        wr_data = 8'($urandom);
`ifdef UART_TX_PARITY_EN
        parityOdd = 1'($urandom);
`endif
        reset = ($urandom_range(0, 299) != 0);
        @(negedge clk);
      end
    end
    reset = 1'b1;
    wr_en = 1'b0;
    repeat (6 * FRAME) @(negedge clk);
    checkOutput("rand_empty", 32'(empty),        32'd1);
    checkOutput("rand_busy",  32'(busy),         32'd0);
    checkOutput("rand_drain", 32'(mSent.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Buffered, parametrised UART transmitter for the Arty SoC top level; the successor to the fixed single-byte `tx` path. The CPU-side peripheral logic pushes bytes into an internal FIFO, and the block serialises them onto `tx` back-to-back. Data width, stop bits, FIFO depth and baud rate are configurable, and FIFO level and overflow status are reported to software.

## Interface
- `CLK_FREQ`, default 20_000_000: clock frequency in Hz.
- `BAUD`, default 115_200: line rate; `DIV = CLK_FREQ/BAUD` (integer truncation), and DIV ≥ 2 is required.
- `DATA_BITS`, default 8: payload bits per frame, legal range 5..8.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, default 16: number of entries; must be a power of 2 and ≥ 2.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `wr_en` input 1: push request.
- `wr_data` input DATA_BITS: byte to push.
- `full` output 1: FIFO holds FIFO_DEPTH entries.
- `empty` output 1: FIFO holds 0 entries.
- `level` output $clog2(FIFO_DEPTH)+1: current entry count.
- `overflow` output 1: sticky flag, set by any push attempted while `full`.
- `busy` output 1: a frame is being shifted out.
- `tx` output 1: serial line, idle high.

## Operation
- Push: when `wr_en && !full`, `wr_data` is written at the rising edge. When `wr_en && full`, the data is dropped and `overflow` is set. Full is evaluated on the registered level, so a push is dropped even if a pop happens in the same cycle.
- Simultaneous push and pop below full: level is unchanged and both operations take effect.
- Pointers are $clog2(FIFO_DEPTH) wide and wrap naturally. Level is kept in an extra-width counter.
- FSM states:
  - IDLE: `tx`=1. If FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx`=0 for DIV cycles.
  - DATA: LSB first, DATA_BITS bits, DIV cycles each.
  - PARITY: present only when the parity macro is defined; DIV cycles.
  - STOP: `tx`=1 for STOP_BITS×DIV cycles.
- Leaving STOP: if the FIFO is non-empty, pop and go straight to START with no idle bit; otherwise go to IDLE.
- Baud counter counts 0..DIV-1 and is cleared on every state entry. A bit counter tracks DATA bits and STOP bits.
- `busy` = (state ≠ IDLE).
- Reset low forces the following at the next edge, aborting any frame mid-bit with no completion of the frame: state=IDLE, `tx`=1, pointers=0, `level`=0, `empty`=1, `full`=0, `overflow`=0, `busy`=0.
- `overflow` is cleared only by reset.

## Timing
- All outputs are registered.
- Reset values: `tx`=1, `busy`=0, `empty`=1, `full`=0, `level`=0, `overflow`=0.
- Latency: a push at edge N into an idle block pops at edge N+1, and `tx` falls after edge N+1. The start bit therefore appears 2 edges after the write.
- Frame length is (1 + DATA_BITS + P + STOP_BITS) × DIV cycles, where P=1 when parity is compiled in and 0 otherwise.
- Consecutive frames are contiguous while the FIFO is non-empty.
- `level`, `full` and `empty` update at the edge following a push or pop.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds input `parity_odd` (1 bit); 0 selects even parity and 1 selects odd.
  - Inserts the PARITY state after DATA, driving `tx` = ^data ^ `parity_odd`.
  - `parity_odd` is sampled when the word is popped.
- Not defined: no PARITY state and no `parity_odd` port; frames carry no parity bit.

## Structure
- `uart_pkg` holds:
  - the FSM state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - a function computing DIV;
  - the counter width helper.
- Sub-module `sync_fifo` (parametrised width and depth, push/pop/level/full/empty) is instantiated once. The FSM and baud counter stay in `uart_tx_buf`.

## Test plan
All scenarios use CLK_FREQ=40 and BAUD=10, giving DIV=4.
- Reset: hold `reset`=0 for 3 cycles. Required: `tx`=1, `busy`=0, `empty`=1, `level`=0.
- Single byte: push 0xA5 into the idle block. Required:
  - `tx` low 2 edges later;
  - bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each;
  - stop bit high;
  - `busy` drops after 40 cycles.
- Back-to-back: push 0x00, 0xFF, 0x55 in consecutive cycles. Required: `level` peaks at 2, 3 contiguous frames (120 cycles) with no idle gap, then `empty`=1.
- Overflow: with FIFO_DEPTH=4, push 6 bytes while the first frame is shifting. Required: `full`=1, `overflow`=1, and exactly 5 frames sent (1 in flight + 4 buffered).
- Mid-frame reset: assert `reset`=0 in the 3rd data bit. Required: `tx`=1 at the next edge, `level`=0, no further frames.
- Parity (macro defined, STOP_BITS=2): push 0x07 with `parity_odd`=0. Required: parity bit 1, two stop bits, frame of 48 cycles.
